// File: rtl/uart_apb_master.sv
// -----------------------------------------------------------------------------
// uart_apb_master
//   APB3 initiator. Accepts one command (addr, wdata, write) on a valid/ready
//   stream, runs it as an APB3 SETUP/ACCESS transfer and returns the result on
//   a valid/ready response stream. Only one transfer is in flight at a time.
//   An ACCESS-phase timeout aborts the transfer if the slave never responds.
//
// Ports
//   i_apb_pclk, i_apb_presetn         clock, async active-low reset
//   i_cmd_valid / o_cmd_ready         command handshake
//   i_cmd_addr, i_cmd_wdata, i_cmd_write  command payload
//   o_rsp_valid / i_rsp_ready         response handshake
//   o_rsp_rdata, o_rsp_error, o_rsp_timeout  response payload
//   o_busy                            transfer in progress (state != IDLE)
//   o_apb_*                           APB3 request signals
//   i_apb_prdata, i_apb_pready, i_apb_pslverr  APB3 completion signals
// -----------------------------------------------------------------------------
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      i_apb_pclk,
  input  logic                      i_apb_presetn,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
  input  logic                      i_cmd_write,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_error,
  output logic                      o_rsp_timeout,
  output logic                      o_busy,
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr
);

  localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int TMO_LAST_I = TMO_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

  // All outputs are registered, so each state computes the bus values that
  // become visible after the next edge:
  //   SETUP  : raises psel (bus SETUP phase follows)
  //   ACCESS : first raises penable, then waits for pready / timeout
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_error_q, rsp_error_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic                      busy_q, busy_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [CNT_W-1:0]          tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    tmo_cnt_d     = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        // cmd_ready comes up one clock after reset release and after each
        // response handshake; acceptance uses the registered value.
        cmd_ready_d = 1'b1;
        if (i_cmd_valid && cmd_ready_q) begin
          paddr_d     = i_cmd_addr;
          pwdata_d    = i_cmd_wdata;
          pwrite_d    = i_cmd_write;
          cmd_ready_d = 1'b0;
          state_d     = S_SETUP;
        end
      end

      S_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        tmo_cnt_d = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (!penable_q) begin
          // Bus is in its SETUP phase now; enter ACCESS next cycle.
          penable_d = 1'b1;
        end else if (i_apb_pready) begin
          // pready wins over a timeout expiring in the same cycle.
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : i_apb_prdata;
          rsp_error_d   = i_apb_pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (TMO_EN && (tmo_cnt_q >= TMO_LAST)) begin
          // This is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        rsp_valid_d = 1'b1;
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_error   = rsp_error_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign o_busy        = busy_q;
  assign o_apb_paddr   = paddr_q;
  assign o_apb_pwdata  = pwdata_q;
  assign o_apb_pwrite  = pwrite_q;
  assign o_apb_psel    = psel_q;
  assign o_apb_penable = penable_q;

endmodule
